// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write-back path.
// The optional starvation guard in the top level is enabled by defining STARVE_GUARD_EN.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // The jal link address always lands in the return-address register.
  localparam int LINK_REG = 31;

  // Requester indices; a lower index means a higher base priority.
  localparam int NUM_REQ  = 3;
  localparam int REQ_MEM  = 0;
  localparam int REQ_LINK = 1;
  localparam int REQ_ALU  = 2;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Keeps only the lowest set bit, which is the highest-priority requester.
  function automatic req_vec_t pick_first(input req_vec_t req);
    return req & (~req + req_vec_t'(1));
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at dispatch and
// cleared by the write-back, with two combinational query ports for decode.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_query,
  input  logic [ADDR_W-1:0] rt_query,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned; a missing default is how latches get inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    // Applied after the clear so a re-dispatch of the retiring register wins.
    if (set_en && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: the busy vector is a plain flop array, not a RAM, so it is reset;
  // a reset mid-operation must forget every pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      busy_q <= busy_d;
    end
  end

  assign rs_busy = busy_q[rs_query];
  assign rt_busy = busy_q[rt_query];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter (mem > link > alu) driving the register-file write port,
// plus the pending-write scoreboard. Define STARVE_GUARD_EN for starvation promotion.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
`ifdef STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,

  input  logic              link_valid,
  output logic              link_ready,
  input  logic [DATA_W-1:0] link_data,

  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,

  input  logic              disp_valid,
  input  logic [ADDR_W-1:0] disp_rd,
  input  logic [ADDR_W-1:0] rs_query,
  input  logic [ADDR_W-1:0] rt_query,
  output logic              rs_busy,
  output logic              rt_busy,

  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  req_vec_t          req_valid;
  req_vec_t          pool;
  req_vec_t          grant;
  logic [ADDR_W-1:0] req_addr [NUM_REQ];
  logic [DATA_W-1:0] req_data [NUM_REQ];
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              commit;

  assign req_valid[REQ_MEM]  = mem_valid;
  assign req_valid[REQ_LINK] = link_valid;
  assign req_valid[REQ_ALU]  = alu_valid;

  assign req_addr[REQ_MEM]   = mem_rd;
  assign req_addr[REQ_LINK]  = ADDR_W'(LINK_REG);
  assign req_addr[REQ_ALU]   = alu_rd;

  assign req_data[REQ_MEM]   = mem_data;
  assign req_data[REQ_LINK]  = link_data;
  assign req_data[REQ_ALU]   = alu_data;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt [NUM_REQ];
  req_vec_t         starved;
  req_vec_t         starved_valid;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Starved requesters compete only among themselves, still in base order.
  assign starved_valid = req_valid & starved;
  assign pool          = (|starved_valid) ? starved_valid : req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (!starved[i]) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign pool = req_valid;
`endif

  // Held in reset, nobody may be granted: the handshake must not complete.
  assign grant = rst_n ? pick_first(pool) : '0;

  assign mem_ready  = grant[REQ_MEM];
  assign link_ready = grant[REQ_LINK];
  assign alu_ready  = grant[REQ_ALU];

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  // A grant to register 0 is accepted and silently dropped.
  assign commit = (|grant) && (sel_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= commit;
      if (commit) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (disp_valid),
    .set_addr (disp_rd),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .rs_query (rs_query),
    .rt_query (rt_query),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy)
  );

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32×32 register file. It shares the file's single write port (WriteEnable/rd/write_data_in) between three requesters: ALU result, memory load data, and the jal link address. It also tracks destination registers with writes still in flight, so decode can stall on rs/rt hazards.

## Interface
- DATA_W, 32: write data width
- ADDR_W, 5: register address width (32 registers)
- STARVE_LIMIT, 4: consecutive lost cycles before a requester is promoted (only with STARVE_GUARD_EN)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); release synchronised externally
- mem_valid / mem_ready  in/out  1/1  load write-back handshake
- mem_rd, mem_data  in  ADDR_W, DATA_W  load destination and data
- link_valid / link_ready  in/out  1/1  jal link handshake
- link_data  in  DATA_W  return address; destination is fixed at register 31
- alu_valid / alu_ready  in/out  1/1  ALU write-back handshake
- alu_rd, alu_data  in  ADDR_W, DATA_W  ALU destination and data
- disp_valid, disp_rd  in  1, ADDR_W  decode issued an instruction that will write disp_rd
- rs_query, rt_query  in  ADDR_W  decode source addresses
- rs_busy, rt_busy  out  1  combinational: queried register has a pending write
- wr_en, wr_addr, wr_data  out  1, ADDR_W, DATA_W  registered drive to the register file write port

## Operation
- Transfer on a requester occurs when valid && ready in the same cycle. Ready is combinational from valid and the arbiter state. At most one ready is high per cycle.
- A requester must hold valid, rd and data stable until its transfer occurs.
- Base priority: mem > link > alu.
- Granted request is registered: next cycle wr_en=1 with the captured wr_addr/wr_data, for exactly one cycle. Otherwise wr_en=0; wr_addr/wr_data hold their last values.
- Address 0: the request is still granted (ready=1), but wr_en stays 0. Register 0 is never written and never marked busy.
- Scoreboard: 32 busy bits.
  - disp_valid sets busy[disp_rd]; disp_rd=0 is ignored.
  - The cycle wr_en=1 clears busy[wr_addr].
  - Set and clear of the same address in one cycle: set wins.
- rs_busy = busy[rs_query]; rt_busy = busy[rt_query]. A clear takes effect in the cycle after wr_en. Forwarding is not provided; decode stalls until busy=0.
- Outputs during/after reset:
  - wr_en=0, wr_addr=0, wr_data=0.
  - All busy bits 0, all starvation counters 0.
  - All ready=0 while reset=0.
- Reset mid-operation: in-flight grants are discarded with no write; pending busy bits are cleared.

## Timing
- Grant latency: 0 cycles (ready in the same cycle as valid when winning).
- Write latency: 1 cycle (transfer at edge N → wr_en high during cycle N+1). The register file captures it on its falling clock edge within that cycle.
- Throughput: one write per cycle, sustained back-to-back.
- Worst-case wait for alu:
  - Unbounded without STARVE_GUARD_EN.
  - STARVE_LIMIT+1 cycles with it.
- Combinational paths:
  - valid → ready.
  - query → busy.
  - No path from ready to valid is allowed on the requester side.

## Configuration
- STARVE_GUARD_EN defined:
  - Each requester has a saturating wait counter. It increments each cycle it is valid and not granted, and clears on grant or when valid is low.
  - A requester whose counter reaches STARVE_LIMIT beats all non-starved requesters.
  - Ties among starved requesters resolve by base priority.
- STARVE_GUARD_EN undefined: pure fixed priority; counters are not built.

## Structure
- Shared package regfile_pkg:
  - DATA_W and ADDR_W defaults.
  - LINK_REG = 31.
  - Requester index constants REQ_MEM=0, REQ_LINK=1, REQ_ALU=2.
- Sub-module wb_scoreboard holds the busy vector, the set/clear logic and the two query ports.
- The top level holds the arbiter, the optional starvation counters and the output register.

## Test plan
- Reset: drive reset=0 with all valids high → all ready=0, wr_en=0, busy=0. Release → mem_ready=1 the same cycle.
- Simultaneous requests: mem(rd=5, 0xAAAA) and alu(rd=6, 0x1234) valid at cycle 0.
  - Cycle 0: mem granted; cycle 1: alu granted.
  - wr_en with 5/0xAAAA in cycle 1, then 6/0x1234 in cycle 2.
- jal link: link_valid with link_data=0x0040_0010 → wr_addr=31, wr_data=0x0040_0010 one cycle later.
- Register 0: alu_rd=0 → alu_ready=1, wr_en stays 0; disp_rd=0 leaves busy[0]=0.
- Scoreboard:
  - disp rd=8 → rt_query=8 gives rt_busy=1.
  - alu write to 8 → busy clears the cycle after wr_en.
  - Dispatch rd=8 in the same cycle as wr_en for 8 → busy stays 1.
- Starvation (STARVE_GUARD_EN, STARVE_LIMIT=4): mem valid continuously with alu valid → alu granted on its 5th cycle, then mem resumes.
